twiddle_idx_gen: RTL and testbench

Sequencer that produces the twiddle-factor index stream for the 384-point FFT datapath. It drives `rom_384` through that ROM's `din_num`/`din_vld` request interface. For each configured pass it emits `k*step mod 384` for `k = 0..len-1`, repeated `rep+1` times. Per-cycle stall from the butterfly engine holds the stream. It sits between the FFT stage controller (which configures and starts it) and the twiddle ROM (which consumes its output).

---
 rtl/fft384_pkg.sv | 34 +++
 rtl/mod384_acc.sv | 33 +++
 rtl/twiddle_idx_gen.sv | 196 +++++++++++++++++++
 tb/tb_twiddle_idx_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fft384_pkg.sv
// -----------------------------------------------------------------------------
// fft384_pkg
// Shared definitions for the 384-point FFT datapath: transform size, index
// width, twiddle ROM word component width, the twiddle sequencer state
// encoding and a modular add helper for index arithmetic.
// -----------------------------------------------------------------------------
package fft384_pkg;

    localparam int N_FFT   = 384;
    localparam int A_WIDTH = 9;
    localparam int R_WIDTH = 8;
    // Width of each cos / sin component held in one twiddle ROM word.
    localparam int COS_SIN = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } tw_state_t;

    // (a + b) mod N_FFT for operands already below N_FFT. The sum needs one
    // extra bit, and a single conditional subtract is enough because the sum
    // is always below 2*N_FFT.
    function automatic logic [A_WIDTH-1:0] mod_add(input logic [A_WIDTH-1:0] a,
                                                   input logic [A_WIDTH-1:0] b);
        logic [A_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (A_WIDTH+1)'(N_FFT)) begin
            sum = sum - (A_WIDTH+1)'(N_FFT);
        end
        return sum[A_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/mod384_acc.sv
// -----------------------------------------------------------------------------
// mod384_acc
// Modular index accumulator: acc <= (acc + step) mod N_FFT when enabled.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset (acc -> 0)
//   clr   in   clear acc to 0 (wins over en)
//   en    in   advance acc by step
//   step  in   A_WIDTH step, must be < N_FFT
//   acc   out  A_WIDTH current accumulator value
// -----------------------------------------------------------------------------
module mod384_acc
    import fft384_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [A_WIDTH-1:0] step,
    output logic [A_WIDTH-1:0] acc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= mod_add(acc, step);
        end
    end

endmodule

// File: rtl/twiddle_idx_gen.sv
// -----------------------------------------------------------------------------
// twiddle_idx_gen
// Issues the twiddle index stream k*step mod N_FFT, k = 0..len-1, repeated
// rep+1 times, towards the twiddle ROM request interface.
//
//   state | meaning
//   IDLE  | waiting for start; index 0 is issued on the accepting edge
//   RUN   | issuing indices (stall holds), or the gap cycle before done
//   FIN   | done (and err) visible for one cycle, then back to IDLE
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle request, sampled only in IDLE
//   cfg_step/len/rep  pass configuration, latched on accepted start
//   stall             hold the stream this cycle
//   din_num, din_vld  registered index and valid towards the ROM
//   busy, done, err   registered status
// -----------------------------------------------------------------------------
module twiddle_idx_gen #(
    parameter int N_FFT   = fft384_pkg::N_FFT,
    parameter int A_WIDTH = fft384_pkg::A_WIDTH,
    parameter int R_WIDTH = fft384_pkg::R_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] cfg_step,
    input  logic [A_WIDTH-1:0] cfg_len,
    input  logic [R_WIDTH-1:0] cfg_rep,
    input  logic               stall,
    output logic [A_WIDTH-1:0] din_num,
    output logic               din_vld,
    output logic               busy,
    output logic               done,
    output logic               err
);

    import fft384_pkg::*;

    localparam logic [A_WIDTH-1:0] N_IDX = A_WIDTH'(N_FFT);

    tw_state_t state_q, state_d;

    logic [A_WIDTH-1:0] step_q, step_d;
    logic [A_WIDTH-1:0] len_q, len_d;
    logic [R_WIDTH-1:0] rep_q, rep_d;
    logic [R_WIDTH-1:0] pass_q, pass_d;
    logic [A_WIDTH-1:0] k_q, k_d;
    logic               last_q, last_d;

    logic [A_WIDTH-1:0] num_d;
    logic               vld_d, busy_d, done_d, err_d;

    logic [A_WIDTH-1:0] len_eff;
    logic               step_ok;
    logic               in_idle;
    logic               issue;
    logic               end_of_pass;
    logic [A_WIDTH-1:0] cur_k, cur_len, cur_step;
    logic [R_WIDTH-1:0] cur_pass, cur_rep;

    logic               acc_clr, acc_en;
    logic [A_WIDTH-1:0] acc_step, acc;

    mod384_acc u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .en   (acc_en),
        .step (acc_step),
        .acc  (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            pass_q  <= '0;
            k_q     <= '0;
            last_q  <= 1'b0;
            din_num <= '0;
            din_vld <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            pass_q  <= pass_d;
            k_q     <= k_d;
            last_q  <= last_d;
            din_num <= num_d;
            din_vld <= vld_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    always_comb begin
        len_eff = (cfg_len > N_IDX) ? N_IDX : cfg_len;
        step_ok = (cfg_step < N_IDX);
        in_idle = (state_q == IDLE);

        // In IDLE the first index is issued straight from the incoming
        // configuration; acc, k and pass are all zero there.
        cur_k    = in_idle ? '0       : k_q;
        cur_pass = in_idle ? '0       : pass_q;
        cur_len  = in_idle ? len_eff  : len_q;
        cur_rep  = in_idle ? cfg_rep  : rep_q;
        cur_step = in_idle ? cfg_step : step_q;

        issue = (in_idle && start && step_ok && (len_eff != '0)) ||
                ((state_q == RUN) && !last_q && !stall);
        end_of_pass = (cur_k == cur_len - 1'b1);

        state_d  = state_q;
        step_d   = step_q;
        len_d    = len_q;
        rep_d    = rep_q;
        pass_d   = pass_q;
        k_d      = k_q;
        last_d   = last_q;
        num_d    = din_num;
        vld_d    = 1'b0;
        busy_d   = busy;
        done_d   = 1'b0;
        err_d    = 1'b0;
        acc_clr  = (state_q != RUN);
        acc_en   = 1'b0;
        acc_step = cur_step;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (!step_ok) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (len_eff == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        step_d  = cfg_step;
                        len_d   = len_eff;
                        rep_d   = cfg_rep;
                    end
                end
            end
            RUN: begin
                // last_q marks the gap cycle after the final index, so done
                // lands one cycle after the last din_vld while in FIN.
                if (last_q) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    last_d  = 1'b0;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (issue) begin
            num_d = acc;
            vld_d = 1'b1;
            if (end_of_pass) begin
                k_d     = '0;
                acc_clr = 1'b1;
                if (cur_pass == cur_rep) begin
                    last_d = 1'b1;
                    pass_d = '0;
                end else begin
                    pass_d = cur_pass + 1'b1;
                end
            end else begin
                k_d     = cur_k + 1'b1;
                acc_clr = 1'b0;
                acc_en  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_idx_gen.sv
// -----------------------------------------------------------------------------
// tb_twiddle_idx_gen
// Directed bench for twiddle_idx_gen with hand-computed index streams and
// done timing. Inputs change 1 ns after the rising edge; outputs are read
// at that same point, i.e. they show the result of the edge just passed.
// -----------------------------------------------------------------------------
module tb_twiddle_idx_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] cfg_step = '0;
    logic [8:0] cfg_len = '0;
    logic [7:0] cfg_rep = '0;
    logic       stall = 1'b0;
    logic [8:0] din_num;
    logic       din_vld;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int failures = 0;
    int exp_idx[$];

    twiddle_idx_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cfg_step (cfg_step),
        .cfg_len  (cfg_len),
        .cfg_rep  (cfg_rep),
        .stall    (stall),
        .din_num  (din_num),
        .din_vld  (din_vld),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Starts one stream and follows it until done. stall is held high while
    // observing cycles [stall_at, stall_at+stall_n); start is re-pulsed with a
    // different config in cycle poke_at to show it is ignored while busy.
    task automatic run(input string tag, input int stp, input int len,
                       input int rep, input int stall_at, input int stall_n,
                       input int poke_at, input int exp_done);
        int n;
        int done_cyc;
        cfg_step = 9'(stp);
        cfg_len  = 9'(len);
        cfg_rep  = 8'(rep);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        n        = 0;
        done_cyc = -1;
        for (int c = 1; c <= exp_done + 20 && done_cyc < 0; c++) begin
            check({tag, "_busy"}, int'(busy), 1);
            if (din_vld) begin
                if (n < exp_idx.size()) begin
                    check({tag, "_idx"}, int'(din_num), exp_idx[n]);
                end
                n++;
            end
            if (done) begin
                done_cyc = c;
                check({tag, "_err"}, int'(err), 0);
                check({tag, "_vld_at_done"}, int'(din_vld), 0);
            end
            stall = (c >= stall_at) && (c < stall_at + stall_n);
            start = (c == poke_at);
            if (c == poke_at) begin
                cfg_step = 9'd5;
                cfg_len  = 9'd2;
            end
            if (done_cyc < 0) begin
                tick();
            end
        end
        check({tag, "_count"}, n, exp_idx.size());
        check({tag, "_done_cyc"}, done_cyc, exp_done);
        stall = 1'b0;
        start = 1'b0;
        tick();
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_done_after"}, int'(done), 0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_num", int'(din_num), 0);
        check("rst_vld", int'(din_vld), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;
        tick();

        exp_idx = '{0, 1, 2, 3};
        run("step1_len4", 1, 4, 0, 0, 0, 0, 5);

        exp_idx = '{0, 100, 200, 300, 16};
        run("step100_wrap", 100, 5, 0, 0, 0, 0, 6);

        exp_idx.delete();
        for (int k = 0; k < 384; k++) exp_idx.push_back((384 - k) % 384);
        run("step383_len384", 383, 384, 0, 0, 0, 0, 385);

        exp_idx = '{0, 2, 4, 0, 2, 4};
        run("step2_rep1", 2, 3, 1, 0, 0, 0, 7);

        exp_idx = '{0, 1, 2, 3, 4, 5};
        run("stall2", 1, 6, 0, 2, 2, 0, 9);

        exp_idx = '{0, 0, 0};
        run("len1_rep2", 5, 1, 2, 0, 0, 0, 4);

        exp_idx.delete();
        for (int k = 0; k < 384; k++) exp_idx.push_back(k);
        run("len_clamp", 1, 500, 0, 0, 0, 0, 385);

        exp_idx = '{0, 1, 2, 3};
        run("start_ignored", 1, 4, 0, 0, 0, 2, 5);

        // Illegal step: err and done together, no index
        cfg_step = 9'd384;
        cfg_len  = 9'd4;
        cfg_rep  = 8'd0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("bad_step_err", int'(err), 1);
        check("bad_step_done", int'(done), 1);
        check("bad_step_vld", int'(din_vld), 0);
        check("bad_step_busy", int'(busy), 1);
        tick();
        check("bad_step_err_clr", int'(err), 0);
        check("bad_step_done_clr", int'(done), 0);
        check("bad_step_busy_clr", int'(busy), 0);

        // len 0, with start held through done: ignored in FIN, taken in IDLE
        cfg_step = 9'd3;
        cfg_len  = 9'd0;
        start    = 1'b1;
        tick();
        check("len0_done", int'(done), 1);
        check("len0_err", int'(err), 0);
        check("len0_vld", int'(din_vld), 0);
        tick();
        check("len0_fin_ignore", int'(done), 0);
        check("len0_idle_busy", int'(busy), 0);
        tick();
        start = 1'b0;
        check("len0_again_done", int'(done), 1);
        tick();
        check("len0_again_clr", int'(done), 0);

        // Reset in mid-run, then a fresh stream from index 0
        cfg_step = 9'd1;
        cfg_len  = 9'd6;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        check("mid_num", int'(din_num), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_num", int'(din_num), 0);
        check("mid_rst_vld", int'(din_vld), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_err", int'(err), 0);
        tick();
        exp_idx = '{0, 7};
        run("after_rst", 7, 2, 0, 0, 0, 0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
